// File: rtl/vec_mem_seq.sv
// Vector memory sequencer: turns one lv/sv command into VLEN_WORDS word
// transfers on the bram_rv ready/valid port, then pulses done (with err on misalignment).
module vec_mem_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int VLEN_WORDS = 8
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_cmd_valid,
  output logic                             o_cmd_ready,
  input  logic                             i_cmd_store,
  input  logic [31:0]                      i_cmd_addr,
  input  logic [VLEN_WORDS*DATA_WIDTH-1:0] i_vreg_data,
  output logic [VLEN_WORDS*DATA_WIDTH-1:0] o_vreg_data,
  output logic                             o_done,
  output logic                             o_err,
  output logic [ADDR_WIDTH-1:0]            o_mem_addr,
  output logic [DATA_WIDTH-1:0]            o_mem_data,
  output logic                             o_mem_wr_valid,
  input  logic                             i_mem_wr_ready,
  output logic                             o_mem_rd_ready,
  input  logic                             i_mem_rd_valid,
  input  logic [DATA_WIDTH-1:0]            i_mem_data,
  output logic [DATA_WIDTH/8-1:0]          o_mem_byte_write_enable
);

  localparam int KW  = (VLEN_WORDS > 1) ? $clog2(VLEN_WORDS) : 1;
  localparam int BEW = DATA_WIDTH / 8;
  localparam int VW  = VLEN_WORDS * DATA_WIDTH;
  localparam logic [KW-1:0] K_LAST = KW'(VLEN_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STORE, S_DONE} state_t;

  state_t                state_q;
  logic [KW-1:0]         k_q;
  logic [KW-1:0]         k_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic                  cmd_ready_q;
  logic                  done_q;
  logic                  err_q;
  logic                  wr_valid_q;
  logic                  rd_ready_q;
  logic [BEW-1:0]        be_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [VW-1:0]         vreg_q;
  logic [DATA_WIDTH-1:0] buf_q [VLEN_WORDS];

  // Only the word-address bits and the alignment bits of the byte address matter.
  logic unused_addr_hi;
  assign unused_addr_hi = ^i_cmd_addr[31:ADDR_WIDTH+2];

  assign k_d    = k_q + KW'(1);
  assign addr_d = addr_q + ADDR_WIDTH'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      addr_q      <= '0;
      cmd_ready_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      wr_valid_q  <= 1'b0;
      rd_ready_q  <= 1'b0;
      be_q        <= '0;
      wdata_q     <= '0;
      vreg_q      <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            k_q         <= '0;
            addr_q      <= i_cmd_addr[ADDR_WIDTH+1:2];
            if (i_cmd_store) begin
              for (int i = 0; i < VLEN_WORDS; i++)
                buf_q[i] <= i_vreg_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
            if (i_cmd_addr[1:0] != 2'b00) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else if (i_cmd_store) begin
              state_q    <= S_STORE;
              wr_valid_q <= 1'b1;
              be_q       <= '1;
              wdata_q    <= i_vreg_data[DATA_WIDTH-1:0];
            end else begin
              state_q    <= S_LOAD;
              rd_ready_q <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (i_mem_rd_valid) begin
            for (int i = 0; i < VLEN_WORDS; i++)
              if (k_q == KW'(i)) vreg_q[i*DATA_WIDTH +: DATA_WIDTH] <= i_mem_data;
            if (k_q == K_LAST) begin
              state_q    <= S_DONE;
              done_q     <= 1'b1;
              rd_ready_q <= 1'b0;
            end else begin
              k_q    <= k_d;
              addr_q <= addr_d;
            end
          end
        end
        S_STORE: begin
          // A low ready is a stall: address and data stay put.
          if (i_mem_wr_ready) begin
            if (k_q == K_LAST) begin
              state_q    <= S_DONE;
              done_q     <= 1'b1;
              wr_valid_q <= 1'b0;
              be_q       <= '0;
            end else begin
              k_q     <= k_d;
              addr_q  <= addr_d;
              wdata_q <= buf_q[k_d];
            end
          end
        end
        S_DONE: begin
          state_q     <= S_IDLE;
          cmd_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= S_IDLE;
          cmd_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign o_cmd_ready             = cmd_ready_q;
  assign o_vreg_data             = vreg_q;
  assign o_done                  = done_q;
  assign o_err                   = err_q;
  assign o_mem_addr              = addr_q;
  assign o_mem_data              = wdata_q;
  assign o_mem_wr_valid          = wr_valid_q;
  assign o_mem_rd_ready          = rd_ready_q;
  assign o_mem_byte_write_enable = be_q;

endmodule

// File: doc/vec_mem_seq.md
# vec_mem_seq

Vector memory sequencer between the execute stage's vector load/store path (`lv`/`sv`) and the `bram_rv` data port. It accepts one vector command, then issues `VLEN_WORDS` consecutive word transfers over the `bram_rv` ready/valid interface. Loads gather words into a vector-register image. Stores scatter a captured vector-register image. A single done pulse reports completion, or a misalignment error.

## Interface
Parameters:
- `DATA_WIDTH`, default 32, memory word width in bits (multiple of 8).
- `ADDR_WIDTH`, default 10, word-address width of the memory port.
- `VLEN_WORDS`, default 8, words per vector (8 × 32 bits = 16 halfwords).

Ports:
- `i_clk`, in, 1: clock; one clock domain.
- `i_rst`, in, 1: synchronous, active-high reset.
- `i_cmd_valid`, in, 1: command request.
- `o_cmd_ready`, out, 1: high only in IDLE.
- `i_cmd_store`, in, 1: 1 = store (`sv`), 0 = load (`lv`).
- `i_cmd_addr`, in, 32: byte base address.
- `i_vreg_data`, in, `VLEN_WORDS*DATA_WIDTH`: store source; word k is in bits [k*DATA_WIDTH +: DATA_WIDTH].
- `o_vreg_data`, out, `VLEN_WORDS*DATA_WIDTH`: load result, same packing.
- `o_done`, out, 1: one-cycle completion pulse.
- `o_err`, out, 1: qualifies `o_done`; indicates a misaligned base address.
- `o_mem_addr`, out, `ADDR_WIDTH`: word address to `bram_rv`.
- `o_mem_data`, out, `DATA_WIDTH`: write data.
- `o_mem_wr_valid`, out, 1: write request.
- `i_mem_wr_ready`, in, 1: write accepted in this cycle.
- `o_mem_rd_ready`, out, 1: read request.
- `i_mem_rd_valid`, in, 1: read data valid.
- `i_mem_data`, in, `DATA_WIDTH`: read data.
- `o_mem_byte_write_enable`, out, `DATA_WIDTH/8`: all ones while `o_mem_wr_valid` is high, else 0.

## Operation
- States are IDLE, LOAD, STORE, DONE.
- **IDLE**
  - A command is accepted when `i_cmd_valid && o_cmd_ready`.
  - On accept, latch the base word address `i_cmd_addr[ADDR_WIDTH+1:2]` and clear the index k to 0.
  - For stores, also latch `i_vreg_data` into an internal buffer. Later changes to the inputs have no effect.
  - If `i_cmd_addr[1:0] != 0`, go to DONE with the error flag set. No memory strobe is asserted.
  - Otherwise go to LOAD or STORE according to `i_cmd_store`.
- **Addressing**
  - `o_mem_addr` = base + k, computed modulo 2^ADDR_WIDTH, so it wraps silently.
  - `o_mem_addr` is registered and changes only at the clock edge that advances k.
- **LOAD**
  - `o_mem_rd_ready` is held high in every LOAD cycle.
  - When `i_mem_rd_valid` is high, write `i_mem_data` into word k of `o_vreg_data`, then increment k.
  - After word `VLEN_WORDS-1`, go to DONE.
  - `i_mem_rd_valid` is ignored outside LOAD.
- **STORE**
  - `o_mem_wr_valid` = 1 and `o_mem_data` = buffered word k.
  - When `i_mem_wr_ready` is high, increment k. A low `i_mem_wr_ready` holds address and data stable (stall).
  - After word `VLEN_WORDS-1` is accepted, go to DONE.
- **DONE**
  - `o_done` = 1 for exactly one cycle; `o_err` = the latched error flag.
  - Next state is IDLE.
  - `o_vreg_data` holds its value until the next load writes into it. A misaligned or store command leaves it unchanged.
- `o_mem_wr_valid` and `o_mem_rd_ready` are never high in the same cycle, and both are 0 in IDLE and DONE.
- **Reset**, including mid-operation: state goes to IDLE and the sequence is aborted; a partial store leaves the already-written words in memory. All outputs go to 0, except `o_cmd_ready`, which is 1 from the first cycle after reset. `o_vreg_data` is reset to 0.

## Timing
- Accept edge is C; the first memory cycle is C+1.
- `bram_rv` read behaviour:
  - Valid appears one cycle after `o_mem_rd_ready` is presented with a stable address.
  - `bram_rv` drops valid on the following cycle.
  - Each load word therefore takes 2 cycles. Word k is valid at C+2+2k, and `o_done` is high at C+2·VLEN_WORDS+1.
- Store without stalls: word k is written at C+1+k, and `o_done` is high at C+VLEN_WORDS+1. Each stalled cycle adds one cycle.
- Misaligned command: `o_done` = `o_err` = 1 at C+1.
- Back-to-back commands: next accept no earlier than the IDLE cycle after DONE.

## Test plan
- **Load, aligned base.** Memory words 8..15 = 0x11110000, 0x33332222, …, 0xFFFFEEEE; load from 0x20. Required: `o_mem_addr` steps 8..15, and `o_vreg_data` word0 = 0x11110000, word7 = 0xFFFFEEEE. `o_done` fires 17 cycles after accept with `o_err` = 0.
- **Store then load back.** Store from 0x40 with word k = 0xA5A50000+k. Required: addresses 16..23 are written on consecutive cycles with byte enables 4'hF, and `o_done` fires 9 cycles after accept. A subsequent load from 0x40 returns the identical image.
- **Misaligned base.** Load at 0x22. Required: `o_done` and `o_err` at C+1. No `o_mem_rd_ready` or `o_mem_wr_valid` is ever asserted, and `o_vreg_data` is unchanged.
- **Address wrap.** With `ADDR_WIDTH` = 4, load from 0x38. Required: address sequence 14, 15, 0, 1, 2, 3, 4, 5.
- **Write stall.** Store from 0x40 with `i_mem_wr_ready` low for 3 cycles at word 2. Required: address 18 and its data are held for 4 cycles; `o_done` fires at C+12.
- **Reset mid-load.** Assert `i_rst` for one cycle at word 3 of a load. Required: all strobes are 0 on the next cycle, `o_cmd_ready` = 1, `o_vreg_data` = 0, and no `o_done` pulse. A new load then completes normally.
